// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, sequencer
// states and the default datapath width.
package hilo_pkg;

    localparam int WIDTH_DEF = 32;

    // Op codes 6 and 7 are reserved and decode to nothing.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and keep the difference
// when it is non-negative.
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction carries one extra bit so its sign is never lost.
    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {2'b00, divisor};
        q_bit    = ~diff[WIDTH+1];
        rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit for the execute stage. Multiplies go through the
// external Booth multiplier (mul_a/mul_b out, signed prod back); unsigned
// products are corrected here. The iterative restoring divider is built only
// when HILO_DIV_EN is defined; otherwise DIV/DIVU decode as reserved ops.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] prod,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    state_e             state;
    logic               is_unsigned;
    logic [2*WIDTH-1:0] p_fix;

    // The multiplier is signed-only; for unsigned operands add back the
    // other operand shifted up wherever an MSB was read as negative.
    always_comb begin
        p_fix = prod;
        if (is_unsigned) begin
            if (mul_a[WIDTH-1]) p_fix = p_fix + {mul_b, {WIDTH{1'b0}}};
            if (mul_b[WIDTH-1]) p_fix = p_fix + {mul_a, {WIDTH{1'b0}}};
        end
    end

`ifdef HILO_DIV_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;     // dividend shifts out the top, quotient in the bottom
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             a_neg;
    logic             b_neg;

    // Operand signs seen at acceptance; only DIV treats MSBs as signs.
    always_comb begin
        a_neg = (op == OP_DIV) && a[WIDTH-1];
        b_neg = (op == OP_DIV) && b[WIDTH-1];
    end

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (dvs),
        .dvd_bit  (dvd[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
`endif

    // Sequencer: accepts requests in IDLE, runs MUL / DIV / FIX, owns HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            is_unsigned <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef HILO_DIV_EN
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_a       <= a;
                                mul_b       <= b;
                                is_unsigned <= (op == OP_MULTU);
                                busy        <= 1'b1;
                                state       <= ST_MUL;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
`ifdef HILO_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                // Work on magnitudes; signs are reapplied in FIX.
                                dvd   <= a_neg ? -a : a;
                                dvs   <= b_neg ? -b : b;
                                neg_q <= a_neg ^ b_neg;
                                neg_r <= a_neg;
                                rem   <= '0;
                                cnt   <= '0;
                                dz    <= (b == '0);
                                busy  <= 1'b1;
                                state <= (b == '0) ? ST_FIX : ST_DIV;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    hi    <= p_fix[2*WIDTH-1:WIDTH];
                    lo    <= p_fix[WIDTH-1:0];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
`ifdef HILO_DIV_EN
                ST_DIV: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    // Divide-by-zero leaves HI/LO untouched and only flags.
                    if (!dz) begin
                        lo <= neg_q ? -dvd : dvd;
                        hi <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                    div_by_zero <= dz;
                    dz          <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized scoreboard bench for hilo_muldiv. The execute-stage Booth
// multiplier is modelled as a plain signed product. Expected HI/LO come from
// plain 64-bit arithmetic on the operands.
module tb_hilo_muldiv;

    localparam int W = 32;
`ifdef HILO_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     op = '0;
    logic [W-1:0]   a = '0, b = '0;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] prod;
    logic           busy, done, div_by_zero;
    logic [W-1:0]   hi, lo;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .mul_a(mul_a), .mul_b(mul_b), .prod(prod), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    assign prod = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_start = 1;
    int busy_end   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: busy window every cycle, and each done pops one expectation.
    always @(negedge clk) begin
        chk("busy", busy, (cyc >= busy_start && cyc <= busy_end));
        if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("res_hi", hi, e.hi);
                chk("res_lo", lo, e.lo);
                chk("res_dbz", div_by_zero, e.dbz);
            end
        end else begin
            chk("dbz_no_done", div_by_zero, 1'b0);
        end
    end

    // Issue one request, update the model, then let it complete. With
    // inject set, a random request is held on start throughout busy.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit inject);
        int c1, lat, guard;
        longint sa, sb;
        longint unsigned ua, ub, r64;
        bit dbz, push;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        c1 = cyc;
        sa = longint'($signed(va)); sb = longint'($signed(vb));
        ua = {32'd0, va};           ub = {32'd0, vb};
        lat = 0; dbz = 1'b0; push = 1'b0;
        case (o)
            3'd0: begin r64 = longint'(sa * sb); {m_hi, m_lo} = r64; lat = 1; push = 1'b1; end
            3'd1: begin r64 = ua * ub; {m_hi, m_lo} = r64; lat = 1; push = 1'b1; end
            3'd2, 3'd3: if (DIV_ON) begin
                push = 1'b1;
                if (vb == '0) begin
                    lat = 1; dbz = 1'b1;
                end else begin
                    lat = W + 1;
                    if (o == 3'd2) begin
                        r64 = longint'(sa / sb); m_lo = r64[W-1:0];
                        r64 = longint'(sa % sb); m_hi = r64[W-1:0];
                    end else begin
                        r64 = ua / ub; m_lo = r64[W-1:0];
                        r64 = ua % ub; m_hi = r64[W-1:0];
                    end
                end
            end
            3'd4: m_hi = va;
            3'd5: m_lo = va;
            default: ;
        endcase
        if (push) begin
            busy_start = c1;
            busy_end   = c1 + lat - 1;
            sbq.push_back('{hi: m_hi, lo: m_lo, dbz: dbz, cyc: c1 + lat});
        end else begin
            busy_start = 1; busy_end = 0;
            chk("imm_hi", hi, m_hi);
            chk("imm_lo", lo, m_lo);
        end
        guard = 0;
        forever begin
            @(negedge clk);
            if (cyc > busy_end) break;
            if (inject) begin
                start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            end
            guard++;
            if (guard > 100) begin
                chk("wait_timeout", guard, 0);
                break;
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        rst_n = 1'b1;

        issue(3'd0, -32'sd3, 32'd7, 1'b0);               // MULT -3*7
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);          // MULTU
        issue(3'd4, 32'h11, 32'd0, 1'b0);                 // MTHI
        issue(3'd5, 32'h22, 32'd0, 1'b0);                 // MTLO
        issue(3'd3, 32'd100, 32'd0, 1'b0);                // DIVU by zero
        issue(3'd2, -32'sd7, 32'd2, 1'b0);                // DIV -7/2
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  // overflow wrap, starts during busy
        issue(3'd6, 32'h1234, 32'h5678, 1'b0);            // reserved
        issue(3'd7, 32'h1234, 32'h5678, 1'b0);            // reserved

        for (int i = 0; i < 60; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0));

        // Reset in the middle of a divide.
        issue(3'd4, 32'h55, 32'd0, 1'b0);
        issue(3'd5, 32'h66, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        c1 = cyc;
        if (DIV_ON) begin busy_start = c1; busy_end = c1 + W; end
        while (cyc < c1 + 9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        busy_start = 1; busy_end = 0;
        m_hi = '0; m_lo = '0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
